udp_frame_builder: RTL and testbench
====================================

Name: udp_frame_builder

Overview:
Successor header inserter for the PL UDP TX path. It buffers one complete payload, then emits an Ethernet+IPv4+UDP frame with correct IPv4 total length, UDP length, IPv4 header checksum and a per-frame incrementing IP identification. Frames shorter than the Ethernet minimum are zero-padded, and oversize payloads are dropped. It sits between the payload source and the MAC TX AXI-Stream. Full AXI-Stream handshakes are honoured on both sides, with no byte loss under backpressure.

Parameters:
MAC_DST, 48'hDA_AA_AA_AA_AA_AA, destination MAC
MAC_SRC, 48'hDE_AD_BE_EF_00_01, source MAC
IP_SRC, 32'hC0A80102, source IPv4 address
IP_DST, 32'hC0A80101, destination IPv4 address
UDP_SRC_PORT, 16'd5000, UDP source port
UDP_DST_PORT, 16'd5000, UDP destination port
IP_TTL, 8'h40, IPv4 TTL
MAX_PAYLOAD, 1472, maximum payload bytes; larger frames are dropped
MIN_FRAME, 60, minimum emitted frame bytes (without FCS); pad target
LEN_W, 11, width of length counters; must satisfy 2^LEN_W > MAX_PAYLOAD

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
s_axis_tdata  in  8  payload byte
s_axis_tvalid  in  1  payload valid
s_axis_tready  out  1  high only in S_FILL and S_DROP
s_axis_tlast  in  1  last payload byte
m_axis_tdata  out  8  frame byte, network order
m_axis_tvalid  out  1  frame byte valid
m_axis_tready  in  1  MAC ready
m_axis_tlast  out  1  last frame byte
drop_pulse  out  1  one-cycle pulse when an oversize payload is discarded
frame_done  out  1  one-cycle pulse on the handshake of the frame's tlast byte

Behaviour:
- Reset values: s_axis_tready=0 during rst; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, drop_pulse=0, frame_done=0; ip_id=0; state=S_FILL.
- After reset, s_axis_tready=1 from the first cycle rst is low.
- States and transitions:
  - S_FILL: each s handshake writes the byte to the buffer at wr_ptr and increments wr_ptr.
    - tlast accepted with byte count L <= MAX_PAYLOAD: latch L, go to S_CSUM.
    - Byte number MAX_PAYLOAD+1 accepted without tlast: go to S_DROP.
    - Byte number MAX_PAYLOAD+1 accepted with tlast: pulse drop_pulse, reset wr_ptr, stay in S_FILL.
  - S_DROP: accept and discard bytes. On tlast: pulse drop_pulse, reset wr_ptr, go to S_FILL. ip_id is not incremented.
  - S_CSUM: lasts one cycle.
    - Compute the 32-bit one's-complement sum of the 10 IPv4 header words with the checksum word set to 0 and total length = 28+L.
    - Fold the carry twice, invert, register as csum.
    - Register ip_len = 28+L and udp_len = 8+L (16-bit).
    - Go to S_HDR.
  - S_HDR: emit header bytes 0..41.
    - 0-13: dst MAC, src MAC, 0x0800.
    - 14-33: 0x45, 0x00, ip_len, ip_id, 0x4000, IP_TTL, 0x11, csum, IP_SRC, IP_DST.
    - 34-41: src port, dst port, udp_len, 0x0000 (UDP checksum disabled).
    - Then go to S_PAY.
  - S_PAY: emit the L buffered bytes in order. Then go to S_PAD if 42+L < MIN_FRAME, else finish.
  - S_PAD: emit 0x00 bytes until the total emitted count equals MIN_FRAME.
  - Finish: tlast is on the final byte (last payload byte, or last pad byte). On its handshake: increment ip_id (16-bit wrap), pulse frame_done, reset wr_ptr, go to S_FILL.
- Output register rule: m_axis_tdata, m_axis_tvalid and m_axis_tlast update only when !m_axis_tvalid || m_axis_tready. Data is held stable while valid && !ready. No bubbles occur when ready is held high.
- Latency: the first header byte is valid 2 cycles after the tlast input handshake. Output is 1 byte/cycle thereafter.
- The buffer is single-frame: input stalls (tready=0) from tlast acceptance until the output frame_done handshake.
- Buffer read is synchronous (1-cycle). The read address is prefetched during header bytes 40-41 so payload is gapless.
- Reset mid-frame: everything returns to reset values on the next edge. Partial input and output frames are abandoned.

Decomposition:
- Package udp_frame_pkg holds:
  - Header byte offsets (ETH_HDR_LEN=14, IP_HDR_LEN=20, UDP_HDR_LEN=8, HDR_LEN=42).
  - ETHERTYPE_IPV4, IP_PROTO_UDP, IP_FLAGS_DF.
  - State encoding.
  - The checksum fold function.
- Sub-module udp_payload_buf: a simple dual-port byte RAM of MAX_PAYLOAD entries with a synchronous read.

Test Plan:
1. 18-byte payload 0x00..0x11 with tready=1 -> 60-byte frame; bytes 16-17=0x002E; bytes 24-25=0xB76B; bytes 38-39=0x001A; no pad; tlast on byte 59.
2. Second frame back-to-back, same 18 bytes -> ip_id=0x0001, checksum 0xB76A, frame_done pulses twice in total.
3. 1-byte payload 0xA5 -> ip_len=0x001D, udp_len=0x0009, byte 42=0xA5, bytes 43-59=0x00, tlast on byte 59, total 60 bytes.
4. 100-byte payload with m_axis_tready toggled pseudo-randomly -> 142 bytes emitted unchanged and in order; tdata is stable whenever valid && !ready.
5. 1473-byte payload -> drop_pulse once after tlast, no m_axis_tvalid, ip_id unchanged; the next 18-byte frame still gives checksum 0xB76B.
6. Assert rst at header byte 20 -> next cycle m_axis_tvalid=0, ip_id=0; a new 18-byte frame is emitted identically to test 1.

Source files
------------

// File: rtl/udp_frame_pkg.sv
// Shared constants, FSM encoding and IPv4 header checksum helpers for the UDP frame builder.
package udp_frame_pkg;

    localparam int unsigned ETH_HDR_LEN = 14;
    localparam int unsigned IP_HDR_LEN  = 20;
    localparam int unsigned UDP_HDR_LEN = 8;
    localparam int unsigned HDR_LEN     = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;

    typedef enum logic [2:0] {
        S_FILL,
        S_DROP,
        S_CSUM,
        S_HDR,
        S_PAY,
        S_PAD,
        S_LAST
    } state_t;

    // Two folds are enough to absorb every carry of a ten-word sum.
    function automatic logic [15:0] csum_fold(input logic [31:0] sum);
        logic [31:0] s;
        s = {16'h0, sum[31:16]} + {16'h0, sum[15:0]};
        s = {16'h0, s[31:16]} + {16'h0, s[15:0]};
        return s[15:0];
    endfunction

    function automatic logic [15:0] ip_hdr_csum(input logic [15:0] ip_len,
                                                input logic [15:0] ip_id,
                                                input logic [7:0]  ttl,
                                                input logic [31:0] src,
                                                input logic [31:0] dst);
        logic [31:0] sum;
        sum = 32'({IP_VER_IHL, 8'h00}) + 32'(ip_len) + 32'(ip_id) + 32'(IP_FLAGS_DF)
            + 32'({ttl, IP_PROTO_UDP}) + 32'(src[31:16]) + 32'(src[15:0])
            + 32'(dst[31:16]) + 32'(dst[15:0]);
        return ~csum_fold(sum);
    endfunction

endpackage

// File: rtl/udp_payload_buf.sv
// Single-frame payload store: simple dual-port byte RAM with a registered read port.
module udp_payload_buf #(
    parameter int unsigned DEPTH  = 1472,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/udp_frame_builder.sv
// Buffers one UDP payload, then emits it behind Ethernet/IPv4/UDP headers on an
// AXI-Stream byte interface, padding short frames and dropping oversize payloads.
module udp_frame_builder #(
    parameter logic [47:0] MAC_DST      = 48'hDA_AA_AA_AA_AA_AA,
    parameter logic [47:0] MAC_SRC      = 48'hDE_AD_BE_EF_00_01,
    parameter logic [31:0] IP_SRC       = 32'hC0A80102,
    parameter logic [31:0] IP_DST       = 32'hC0A80101,
    parameter logic [15:0] UDP_SRC_PORT = 16'd5000,
    parameter logic [15:0] UDP_DST_PORT = 16'd5000,
    parameter logic [7:0]  IP_TTL       = 8'h40,
    parameter int unsigned MAX_PAYLOAD  = 1472,
    parameter int unsigned MIN_FRAME    = 60,
    parameter int unsigned LEN_W        = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       drop_pulse,
    output logic       frame_done
);

    import udp_frame_pkg::*;

    // One extra bit so the emitted-byte index covers header plus payload.
    localparam int unsigned CNT_W = LEN_W + 1;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [15:0]       ip_id_q, ip_id_d;
    logic [15:0]       csum_q, csum_d;
    logic [15:0]       ip_len_q, ip_len_d;
    logic [15:0]       udp_len_q, udp_len_d;
    logic [7:0]        tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              drop_q, drop_d;

    logic              s_hs;
    logic              adv;
    logic              wr_en;
    logic              rd_en;
    logic [LEN_W-1:0]  rd_addr;
    logic [7:0]        rd_data;
    logic [CNT_W-1:0]  pay_idx;
    logic [CNT_W-1:0]  len_ext;
    logic [HDR_LEN*8-1:0] hdr_vec;
    logic [5:0]        hdr_rev;
    logic [7:0]        hdr_byte;

    assign s_axis_tready = !rst && (state_q == S_FILL || state_q == S_DROP);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign adv           = !tvalid_q || m_axis_tready;
    assign pay_idx       = idx_q - CNT_W'(HDR_LEN);
    assign len_ext       = CNT_W'(len_q);

    assign hdr_vec = {MAC_DST, MAC_SRC, ETHERTYPE_IPV4,
                      IP_VER_IHL, 8'h00, ip_len_q, ip_id_q, IP_FLAGS_DF,
                      IP_TTL, IP_PROTO_UDP, csum_q, IP_SRC, IP_DST,
                      UDP_SRC_PORT, UDP_DST_PORT, udp_len_q, 16'h0000};
    // Byte 0 sits in the most significant position of hdr_vec.
    assign hdr_rev  = 6'(HDR_LEN - 1) - idx_q[5:0];
    assign hdr_byte = hdr_vec[{hdr_rev, 3'b000} +: 8];

    udp_payload_buf #(
        .DEPTH (MAX_PAYLOAD),
        .ADDR_W(LEN_W)
    ) u_buf (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr_q),
        .wr_data(s_axis_tdata),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        len_d     = len_q;
        idx_d     = idx_q;
        ip_id_d   = ip_id_q;
        csum_d    = csum_q;
        ip_len_d  = ip_len_q;
        udp_len_d = udp_len_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        drop_d    = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;

        unique case (state_q)
            S_FILL: begin
                if (s_hs) begin
                    if (wr_ptr_q == LEN_W'(MAX_PAYLOAD)) begin
                        if (s_axis_tlast) begin
                            drop_d   = 1'b1;
                            wr_ptr_d = '0;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (s_axis_tlast) begin
                            len_d   = wr_ptr_q + 1'b1;
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_DROP: begin
                if (s_hs && s_axis_tlast) begin
                    drop_d   = 1'b1;
                    wr_ptr_d = '0;
                    state_d  = S_FILL;
                end
            end
            S_CSUM: begin
                ip_len_d  = 16'(IP_HDR_LEN + UDP_HDR_LEN) + 16'(len_q);
                udp_len_d = 16'(UDP_HDR_LEN) + 16'(len_q);
                csum_d    = ip_hdr_csum(ip_len_d, ip_id_q, IP_TTL, IP_SRC, IP_DST);
                idx_d     = '0;
                state_d   = S_HDR;
            end
            S_HDR: begin
                if (adv) begin
                    tdata_d  = hdr_byte;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    idx_d    = idx_q + 1'b1;
                    // Fetch payload byte 0 now so it is ready right after the header.
                    if (idx_q == CNT_W'(HDR_LEN - 1)) begin
                        rd_en   = 1'b1;
                        state_d = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (adv) begin
                    tdata_d  = rd_data;
                    tvalid_d = 1'b1;
                    idx_d    = idx_q + 1'b1;
                    if (pay_idx == len_ext - 1'b1) begin
                        tlast_d = (CNT_W'(HDR_LEN) + len_ext) >= CNT_W'(MIN_FRAME);
                        state_d = tlast_d ? S_LAST : S_PAD;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = LEN_W'(pay_idx + 1'b1);
                    end
                end
            end
            S_PAD: begin
                if (adv) begin
                    tdata_d  = 8'h00;
                    tvalid_d = 1'b1;
                    idx_d    = idx_q + 1'b1;
                    if (idx_q == CNT_W'(MIN_FRAME - 1)) begin
                        tlast_d = 1'b1;
                        state_d = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (tvalid_q && m_axis_tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    ip_id_d  = ip_id_q + 1'b1;
                    wr_ptr_d = '0;
                    state_d  = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FILL;
            wr_ptr_q  <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            ip_id_q   <= '0;
            csum_q    <= '0;
            ip_len_q  <= '0;
            udp_len_q <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            ip_id_q   <= ip_id_d;
            csum_q    <= csum_d;
            ip_len_q  <= ip_len_d;
            udp_len_q <= udp_len_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            drop_q    <= drop_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign drop_pulse    = drop_q;
    assign frame_done    = tvalid_q && m_axis_tready && tlast_q;

endmodule

// File: tb/tb_udp_frame_builder.sv
// Directed, table-driven bench for udp_frame_builder with hand-computed header fields.
module tb_udp_frame_builder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_axis_tlast = 1'b0;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       m_axis_tlast;
    logic       drop_pulse;
    logic       frame_done;

    always #5 clk = ~clk;

    udp_frame_builder dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .drop_pulse   (drop_pulse),
        .frame_done   (frame_done)
    );

    typedef struct {
        int          len;
        logic [15:0] id;
        logic [15:0] ip_len;
        logic [15:0] udp_len;
        logic [15:0] csum;
        int          total;
        bit          rand_rdy;
    } vec_t;

    vec_t vecs[4];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_mode = 1'b0;
    logic [7:0] rx_d[$];
    bit         rx_l[$];
    logic [7:0] exp_q[$];
    int   done_cnt = 0;
    int   drop_cnt = 0;
    int   valid_cnt = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    int   hs_cyc = 0;
    bit   in_frame = 1'b0;
    bit   stall = 1'b0;
    logic [7:0] held_d = 8'h00;
    logic       held_l = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pay_byte(input int len, input int i);
        if (len == 1) return 8'hA5;
        if (len == 100) return 8'(i * 3 + 7);
        return 8'(i);
    endfunction

    function automatic logic [7:0] rxb(input int i);
        return (i < rx_d.size()) ? rx_d[i] : 8'h00;
    endfunction

    function automatic bit rxl(input int i);
        return (i < rx_l.size()) ? rx_l[i] : 1'b0;
    endfunction

    function automatic void build_exp(input vec_t v);
        logic [335:0] h;
        h = {48'hDAAAAAAAAAAA, 48'hDEADBEEF0001, 16'h0800, 8'h45, 8'h00, v.ip_len, v.id,
             16'h4000, 8'h40, 8'h11, v.csum, 32'hC0A80102, 32'hC0A80101,
             16'd5000, 16'd5000, v.udp_len, 16'h0000};
        exp_q.delete();
        for (int i = 0; i < 42; i++) exp_q.push_back(h[335 - 8 * i -: 8]);
        for (int i = 0; i < v.len; i++) exp_q.push_back(pay_byte(v.len, i));
        while (exp_q.size() < 60) exp_q.push_back(8'h00);
    endfunction

    // Output monitor: drives MAC ready, collects bytes, checks hold-while-stalled.
    initial begin
        forever begin
            @(negedge clk);
            m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (rst) begin
                in_frame = 1'b0;
                stall    = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
                    chk("hold_data", 32'(m_axis_tdata), 32'(held_d));
                    chk("hold_last", 32'(m_axis_tlast), 32'(held_l));
                end
                if (m_axis_tvalid) begin
                    valid_cnt++;
                    if (!in_frame) begin
                        in_frame  = 1'b1;
                        first_cyc = cyc;
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    rx_d.push_back(m_axis_tdata);
                    rx_l.push_back(m_axis_tlast);
                    if (m_axis_tlast) begin
                        last_cyc = cyc;
                        in_frame = 1'b0;
                    end
                end
                if (frame_done) done_cnt++;
                if (drop_pulse) drop_cnt++;
                stall  = m_axis_tvalid && !m_axis_tready;
                held_d = m_axis_tdata;
                held_l = m_axis_tlast;
            end
        end
    end

    task automatic send(input int len);
        @(posedge clk);
        #1;
        for (int i = 0; i < len; i++) begin
            int t;
            t = 0;
            s_axis_tdata  = pay_byte(len, i);
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == len - 1);
            forever begin
                @(negedge clk);
                #1;
                if (s_axis_tready) break;
                t++;
                if (t > 3000) begin
                    chk("send_timeout", 32'd1, 32'd0);
                    s_axis_tvalid = 1'b0;
                    s_axis_tlast  = 1'b0;
                    return;
                end
            end
            if (i == len - 1) hs_cyc = cyc + 1;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int start_done;
        int t;
        int bad;
        rx_d.delete();
        rx_l.delete();
        build_exp(v);
        rand_mode  = v.rand_rdy;
        start_done = done_cnt;
        send(v.len);
        t = 0;
        while (done_cnt == start_done && t < 5000) begin
            @(negedge clk);
            #2;
            t++;
        end
        rand_mode = 1'b0;
        chk("frame_done_pulse", 32'(done_cnt - start_done), 32'd1);
        chk("frame_length", 32'(rx_d.size()), 32'(v.total));
        chk("ip_len", 32'({rxb(16), rxb(17)}), 32'(v.ip_len));
        chk("ip_id", 32'({rxb(18), rxb(19)}), 32'(v.id));
        chk("ip_csum", 32'({rxb(24), rxb(25)}), 32'(v.csum));
        chk("udp_len", 32'({rxb(38), rxb(39)}), 32'(v.udp_len));
        chk("payload_byte42", 32'(rxb(42)), 32'(pay_byte(v.len, 0)));
        chk("tlast_final", 32'(rxl(v.total - 1)), 32'd1);
        bad = 0;
        for (int i = 0; i < v.total; i++) begin
            if (rxb(i) !== exp_q[i] || rxl(i) != (i == v.total - 1)) bad++;
        end
        chk("frame_bytes_bad", 32'(bad), 32'd0);
        chk("first_byte_latency", 32'(first_cyc - hs_cyc), 32'd2);
        if (!v.rand_rdy) chk("gapless", 32'(last_cyc - first_cyc), 32'(v.total - 1));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #2;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int vc;
        int dc;
        int t;
        vecs[0] = '{18,  16'h0000, 16'h002E, 16'h001A, 16'hB76B, 60,  1'b0};
        vecs[1] = '{18,  16'h0001, 16'h002E, 16'h001A, 16'hB76A, 60,  1'b0};
        vecs[2] = '{1,   16'h0002, 16'h001D, 16'h0009, 16'hB77A, 60,  1'b0};
        vecs[3] = '{100, 16'h0003, 16'h0080, 16'h006C, 16'hB716, 142, 1'b1};

        repeat (3) @(negedge clk);
        #2;
        chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("tready_after_rst", 32'(s_axis_tready), 32'd1);

        for (int k = 0; k < 4; k++) begin
            run_frame(vecs[k]);
            if (k == 1) chk("frame_done_total", 32'(done_cnt), 32'd2);
        end

        // Oversize payload is discarded without touching ip_id.
        apply_reset();
        rx_d.delete();
        rx_l.delete();
        vc = valid_cnt;
        dc = drop_cnt;
        send(1473);
        repeat (5) @(negedge clk);
        #2;
        chk("drop_pulse_count", 32'(drop_cnt - dc), 32'd1);
        chk("drop_no_valid", 32'(valid_cnt - vc), 32'd0);
        chk("drop_no_bytes", 32'(rx_d.size()), 32'd0);
        run_frame(vecs[0]);

        // Reset while header byte 20 is on the output.
        rx_d.delete();
        rx_l.delete();
        send(18);
        t = 0;
        while (rx_d.size() < 20 && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk("reach_hdr_byte20", 32'(rx_d.size()), 32'd20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("mid_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mid_rst_s_tready", 32'(s_axis_tready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("tready_after_mid_rst", 32'(s_axis_tready), 32'd1);
        run_frame(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
